led_trace_capture: RTL and testbench
====================================

# led_trace_capture

Parametrised successor to the single-shot fetch-data LED latch. It records up to DEPTH instruction words returned by L1I to the core (ready_L1I_C & read_C_L1I) into a small trace buffer. Three capture modes are supported: first-N, rolling last-N and trigger-on-value. One selected entry (lower or upper LED_W slice) is driven onto the board LEDs for FPGA bring-up debug. The block sits beside the core/L1I interface as a passive observer and never back-pressures it.

## Interface
- DATA_W, 32, width of fetched instruction word
- LED_W, 16, LED count; DATA_W ≥ LED_W
- DEPTH, 8, trace entries; power of two, ≥ 2
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- ready_L1I_C  in  1  L1I data-valid to core
- read_C_L1I  in  1  core read request to L1I
- read_data_L1I_C  in  DATA_W  fetched word
- mode  in  2  0 FIRST, 1 ROLL, 2 TRIG, 3 reserved (behaves as FIRST)
- trig_value  in  DATA_W  TRIG match value
- rearm  in  1  single-cycle pulse; restart capture
- view_idx  in  $clog2(DEPTH)  logical entry to display; 0 = oldest
- view_hi  in  1  0: bits [LED_W-1:0]; 1: bits [DATA_W-1 -: LED_W]
- LED  out  LED_W  displayed slice, registered
- count  out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
- armed  out  1  state == ARMED
- done  out  1  state == DONE

## Operation
- Event: ready_L1I_C & read_C_L1I high in the same cycle. No other combination captures.
- States: ARMED, CAPTURE, DONE. Reset → ARMED, count=0, wr_ptr=0, LED=0. Buffer contents are not reset.
- mode is latched on the ARMED→CAPTURE transition. Changes to mode in CAPTURE or DONE are ignored.
- ARMED, FIRST/ROLL: any event writes entry 0 and moves to CAPTURE.
- ARMED, TRIG: only an event with data == trig_value writes entry 0 and moves to CAPTURE. Non-matching events are ignored.
- CAPTURE: each event writes buffer[wr_ptr], then wr_ptr++ (mod DEPTH) and count++ (saturating).
- FIRST/TRIG: the event that brings count to DEPTH moves the state to DONE.
- ROLL: stays in CAPTURE indefinitely, wraps and overwrites the oldest entry.
- DONE: events are ignored.
- rearm (any state): state→ARMED, count=0, wr_ptr=0. rearm wins over a same-cycle event, which is dropped.
- Display mapping:
  - physical = (oldest + view_idx) mod DEPTH, where oldest = wr_ptr when count == DEPTH in ROLL, else 0.
  - If view_idx ≥ count, LED is driven to 0.

## Timing
- Event in cycle n: buffer and count are updated at the end of cycle n. LED reflects the new entry at the end of cycle n+1 (2-edge latency).
- A view_idx/view_hi change is reflected on LED after 1 edge.
- done/armed/count change on the edge that processes the event or rearm.
- Back-to-back events every cycle are all captured; there is no throughput limit.
- Reset asserted mid-capture: immediate return to ARMED, count=0, LED=0.

## Structure
- Package led_trace_pkg holds:
  - mode_e: FIRST, ROLL, TRIG
  - state_e: ARMED, CAPTURE, DONE
- Sub-module trace_buffer: DEPTH×DATA_W register file with one write port and one combinational read port. It has no reset on the storage.
- The top level holds the FSM, pointers, the display index mapping and the LED register.

## Test plan
Bench parameters: DATA_W=32, LED_W=16, DEPTH=4.
- Reset: release rstn → LED=0x0000, count=0, armed=1, done=0. Assert rstn mid-capture → the same values immediately.
- FIRST: events 0x11110001…0x11110006 → count=4, done=1. view_idx 0..3 → LED 0x0001..0x0004. view_hi=1 → 0x1111.
- ROLL: six events as above → count=4, done=0. view_idx 0 → 0x0003; view_idx 3 → 0x0006.
- TRIG, trig_value=0xDEAD0000: events 0x1, 0xDEAD0000, 0x2, 0x3, 0x4, 0x5 → entries DEAD0000, 2, 3, 4 and done=1. view_idx0 with view_hi=1 → 0xDEAD.
- Handshake filter: ready_L1I_C=1 with read_C_L1I=0 (and the reverse) for 10 cycles → count stays 0. After 2 events, view_idx=3 → LED=0.
- rearm in DONE coincident with event 0xAAAA0001 → count=0, armed=1, event dropped. The next event 0xAAAA0002 becomes entry 0 → LED=0x0002 two edges later.

Source files
------------

// File: rtl/led_trace_pkg.sv
// Shared types for the LED trace capture block: capture modes and FSM states.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
// Contents: mode_e, state_e, decode_mode().
package led_trace_pkg;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ROLL  = 2'd1,
    TRIG  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Raw mode input to capture mode; the reserved encoding falls back to FIRST.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return ROLL;
      2'd2:    return TRIG;
      default: return FIRST;
    endcase
  endfunction

endpackage

// File: rtl/trace_buffer.sv
// Trace storage: DEPTH x DATA_W register file, one write port, one async read port.
// Latency: write lands on the clock edge; read is combinational from the address.
// Backpressure: none, a write is accepted every cycle we is high.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port. Storage has no reset.
module trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/led_trace_capture.sv
// Passive L1I->core fetch tracer: records up to DEPTH fetched words (first-N,
// rolling last-N or trigger-on-value) and shows one selected entry on the LEDs.
// Latency: count/armed/done update on the capturing edge; LED one edge after that.
// Backpressure: none, observes ready_L1I_C & read_C_L1I and never stalls it.
// Ports: clk/rstn; ready_L1I_C/read_C_L1I/read_data_L1I_C observed bus;
//   mode/trig_value/rearm control; view_idx/view_hi display select;
//   LED, count, armed, done status outputs (all registered).
module led_trace_capture #(
  parameter int DATA_W = 32,
  parameter int LED_W  = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       ready_L1I_C,
  input  logic                       read_C_L1I,
  input  logic [DATA_W-1:0]          read_data_L1I_C,
  input  logic [1:0]                 mode,
  input  logic [DATA_W-1:0]          trig_value,
  input  logic                       rearm,
  input  logic [$clog2(DEPTH)-1:0]   view_idx,
  input  logic                       view_hi,
  output logic [LED_W-1:0]           LED,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       armed,
  output logic                       done
);
  import led_trace_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  mode_e             start_mode;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              capture_ev;
  logic              buf_we;
  logic [AW-1:0]     oldest;
  logic [AW-1:0]     rd_idx;
  logic [DATA_W-1:0] rd_data;

  assign capture_ev = ready_L1I_C & read_C_L1I;
  assign start_mode = decode_mode(mode);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    buf_we   = 1'b0;
    if (rearm) begin
      // rearm beats a coincident capture event, which is simply dropped
      state_d  = ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        ARMED: begin
          // wr_ptr is always 0 here, so this write lands in entry 0
          if (capture_ev && (start_mode != TRIG || read_data_L1I_C == trig_value)) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
            mode_d   = start_mode;
            state_d  = CAPTURE;
          end
        end
        CAPTURE: begin
          if (capture_ev) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != FULL) begin
              count_d = count_q + 1'b1;
            end
            if (mode_q != ROLL && count_q == FULL - 1'b1) begin
              state_d = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Once a rolling trace has wrapped, the write pointer marks the oldest entry.
  assign oldest = (mode_q == ROLL && count_q == FULL) ? wr_ptr_q : '0;
  assign rd_idx = oldest + view_idx;

  always_comb begin
    led_d = '0;
    if ({1'b0, view_idx} < count_q) begin
      led_d = view_hi ? rd_data[DATA_W-1 -: LED_W] : rd_data[LED_W-1:0];
    end
  end

  trace_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_trace_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata (read_data_L1I_C),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ARMED;
      mode_q   <= FIRST;
      wr_ptr_q <= '0;
      count_q  <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      led_q    <= led_d;
    end
  end

  assign LED   = led_q;
  assign count = count_q;
  assign armed = (state_q == ARMED);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_led_trace_capture.sv
// Self-checking bench for led_trace_capture (DATA_W=32, LED_W=16, DEPTH=4).
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a queue-based model of the capture rules.
module tb_led_trace_capture;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ready = 1'b0;
  logic        read = 1'b0;
  logic [31:0] data = '0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] trig = '0;
  logic        rearm = 1'b0;
  logic [1:0]  view_idx = 2'd0;
  logic        view_hi = 1'b0;
  logic [15:0] led;
  logic [2:0]  count;
  logic        armed;
  logic        done;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  // model: state 0 armed, 1 capture, 2 done; mode 0 first, 1 roll, 2 trig
  int          m_state = 0;
  int          m_mode = 0;
  logic [31:0] m_q[$];
  logic [15:0] m_led = '0;

  led_trace_capture #(.DATA_W(32), .LED_W(16), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .ready_L1I_C     (ready),
    .read_C_L1I      (read),
    .read_data_L1I_C (data),
    .mode            (mode),
    .trig_value      (trig),
    .rearm           (rearm),
    .view_idx        (view_idx),
    .view_hi         (view_hi),
    .LED             (led),
    .count           (count),
    .armed           (armed),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the trace is an ordered list of captured words, oldest first.
  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_state = 0;
        m_q.delete();
        m_led = '0;
      end else begin
        if (int'(view_idx) < m_q.size()) begin
          m_led = view_hi ? m_q[view_idx][31:16] : m_q[view_idx][15:0];
        end else begin
          m_led = '0;
        end
        if (rearm) begin
          m_state = 0;
          m_q.delete();
        end else if (ready && read) begin
          if (m_state == 0) begin
            m_mode = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
            if (m_mode != 2 || data == trig) begin
              m_q.push_back(data);
              m_state = 1;
            end
          end else if (m_state == 1) begin
            m_q.push_back(data);
            if (m_mode == 1) begin
              if (m_q.size() > DEPTH) void'(m_q.pop_front());
            end else if (m_q.size() == DEPTH) begin
              m_state = 2;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cyc_led", {16'h0, led}, {16'h0, m_led});
        chk("cyc_count", {29'h0, count}, m_q.size());
        chk("cyc_armed", {31'h0, armed}, {31'h0, m_state == 0});
        chk("cyc_done", {31'h0, done}, {31'h0, m_state == 2});
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ev(input logic [31:0] d);
    ready = 1'b1;
    read  = 1'b1;
    data  = d;
    cyc();
  endtask

  task automatic idle();
    ready = 1'b0;
    read  = 1'b0;
    cyc();
  endtask

  task automatic do_rearm();
    ready = 1'b0;
    read  = 1'b0;
    rearm = 1'b1;
    cyc();
    rearm = 1'b0;
  endtask

  task automatic see(input logic [1:0] idx, input logic hi, input logic [15:0] exp, input string nm);
    view_idx = idx;
    view_hi  = hi;
    cyc();
    chk(nm, {16'h0, led}, {16'h0, exp});
  endtask

  initial begin
    // reset
    repeat (3) cyc();
    rstn = 1'b1;
    cyc();
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_count", {29'h0, count}, 32'd0);
    chk("rst_armed", {31'h0, armed}, 32'd1);
    chk("rst_done", {31'h0, done}, 32'd0);
    cmp_en = 1'b1;

    // FIRST
    mode = 2'd0;
    for (int i = 1; i <= 6; i++) ev(32'h11110000 + i);
    idle();
    chk("first_count", {29'h0, count}, 32'd4);
    chk("first_done", {31'h0, done}, 32'd1);
    for (int v = 0; v < 4; v++) see(2'(v), 1'b0, 16'(v + 1), "first_view");
    see(2'd0, 1'b1, 16'h1111, "first_hi");

    // rearm in DONE with a coincident event: event is dropped
    view_idx = 2'd0;
    view_hi  = 1'b0;
    rearm = 1'b1;
    ready = 1'b1;
    read  = 1'b1;
    data  = 32'hAAAA0001;
    cyc();
    rearm = 1'b0;
    chk("rearm_count", {29'h0, count}, 32'd0);
    chk("rearm_armed", {31'h0, armed}, 32'd1);
    data = 32'hAAAA0002;
    cyc();
    idle();
    chk("rearm_led", {16'h0, led}, 32'h0002);

    // ROLL, then a mode change mid-capture must not stop the roll
    do_rearm();
    mode = 2'd1;
    for (int i = 1; i <= 6; i++) ev(32'h11110000 + i);
    idle();
    chk("roll_count", {29'h0, count}, 32'd4);
    chk("roll_done", {31'h0, done}, 32'd0);
    see(2'd0, 1'b0, 16'h0003, "roll_oldest");
    see(2'd3, 1'b0, 16'h0006, "roll_newest");
    mode = 2'd0;
    for (int i = 7; i <= 9; i++) ev(32'h11110000 + i);
    idle();
    chk("roll_latched", {31'h0, done}, 32'd0);
    see(2'd0, 1'b0, 16'h0006, "roll_wrap");

    // TRIG
    do_rearm();
    mode = 2'd2;
    trig = 32'hDEAD0000;
    ev(32'h1); ev(32'hDEAD0000); ev(32'h2); ev(32'h3); ev(32'h4); ev(32'h5);
    idle();
    chk("trig_count", {29'h0, count}, 32'd4);
    chk("trig_done", {31'h0, done}, 32'd1);
    see(2'd0, 1'b1, 16'hDEAD, "trig_first");
    see(2'd3, 1'b0, 16'h0004, "trig_last");

    // handshake filter
    do_rearm();
    mode = 2'd0;
    for (int i = 0; i < 10; i++) begin
      ready = i[0];
      read  = ~i[0];
      data  = 32'h5555_0000 + i;
      cyc();
    end
    idle();
    chk("filt_count", {29'h0, count}, 32'd0);
    chk("filt_armed", {31'h0, armed}, 32'd1);
    ev(32'h7777_0001); ev(32'h7777_0002);
    idle();
    see(2'd3, 1'b0, 16'h0000, "filt_empty_idx");
    see(2'd1, 1'b0, 16'h0002, "filt_idx1");

    // reset mid-capture
    do_rearm();
    ev(32'h1234_5678); ev(32'h9999_0001);
    idle();
    see(2'd0, 1'b0, 16'h5678, "pre_rst_led");
    #3 rstn = 1'b0;
    #1;
    chk("mid_rst_led", {16'h0, led}, 32'h0);
    chk("mid_rst_count", {29'h0, count}, 32'd0);
    chk("mid_rst_armed", {31'h0, armed}, 32'd1);
    chk("mid_rst_done", {31'h0, done}, 32'd0);
    cyc();
    rstn = 1'b1;
    cyc();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ready    = ($urandom_range(0, 3) != 0);
      read     = ($urandom_range(0, 3) != 0);
      data     = ($urandom_range(0, 3) == 0) ? trig : $urandom;
      rearm    = ($urandom_range(0, 39) == 0);
      mode     = 2'($urandom_range(0, 3));
      view_idx = 2'($urandom_range(0, 3));
      view_hi  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) trig = $urandom;
      cyc();
    end
    rearm = 1'b0;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
